// File: rtl/led_pattern_gen.sv
// Pattern generator driving N_LED LEDs at one step per TICK_DIV clocks.
// Four patterns: fill/drain from LSB, fill/drain from MSB, chaser, bounce.
module led_pattern_gen #(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk50M,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             run,
  output logic [N_LED-1:0] led,
  output logic             tick,
  output logic             cycle_done
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0]    DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [N_LED-1:0] ONES    = '1;
  localparam logic [N_LED-1:0] ONE     = N_LED'(1);

  // FILL doubles as "moving left" and DRAIN as "moving right" in bounce mode
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [1:0]       mode_m_q, mode_s_q, act_q, act_d;
  logic [DW-1:0]    div_q, div_d;
  logic [N_LED-1:0] led_q, led_d, step_led;
  logic [0:0]       state_q, state_d, step_state;
  logic             tick_q, tick_d, done_q, done_d, step_done;

  always_comb begin
    step_led   = led_q;
    step_state = state_q;
    step_done  = 1'b0;
    case (act_q)
      2'd0: begin
        if (state_q == FILL) begin
          step_led = {led_q[N_LED-2:0], 1'b1};
          if (step_led == ONES) step_state = DRAIN;
        end else begin
          step_led = {led_q[N_LED-2:0], 1'b0};
          if (step_led == '0) begin
            step_state = FILL;
            step_done  = 1'b1;
          end
        end
      end
      2'd1: begin
        if (state_q == FILL) begin
          step_led = {1'b1, led_q[N_LED-1:1]};
          if (step_led == ONES) step_state = DRAIN;
        end else begin
          step_led = {1'b0, led_q[N_LED-1:1]};
          if (step_led == '0) begin
            step_state = FILL;
            step_done  = 1'b1;
          end
        end
      end
      2'd2: begin
        step_led  = {led_q[N_LED-2:0], led_q[N_LED-1]};
        step_done = (step_led == ONE);
      end
      default: begin
        if (state_q == FILL) begin
          step_led = led_q << 1;
          if (step_led[N_LED-1]) step_state = DRAIN;
        end else begin
          step_led = led_q >> 1;
          if (step_led[0]) begin
            step_state = FILL;
            step_done  = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    act_d   = act_q;
    div_d   = div_q;
    led_d   = led_q;
    state_d = state_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    // A settled mode change restarts the new pattern even while paused
    if (mode_s_q != act_q) begin
      act_d   = mode_s_q;
      div_d   = '0;
      led_d   = mode_s_q[1] ? ONE : '0;
      state_d = FILL;
    end else if (run) begin
      if (div_q == DIV_MAX) begin
        div_d   = '0;
        led_d   = step_led;
        state_d = step_state;
        tick_d  = 1'b1;
        done_d  = step_done;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      mode_m_q <= '0;
      mode_s_q <= '0;
      act_q    <= '0;
      div_q    <= '0;
      led_q    <= '0;
      state_q  <= FILL;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_m_q <= mode;
      mode_s_q <= mode_m_q;
      act_q    <= act_d;
      div_q    <= div_d;
      led_q    <= led_d;
      state_q  <= state_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign led        = led_q;
  assign tick       = tick_q;
  assign cycle_done = done_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised scoreboard bench for led_pattern_gen in two configurations
// (N_LED=8/TICK_DIV=4 and N_LED=4/TICK_DIV=2) sharing one stimulus.
module tb_led_pattern_gen;
  typedef struct {
    int          cyc;
    logic [31:0] led;
    logic        tk;
    logic        dn;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       run;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // Pattern value at position p of mode m's cycle, built from the pattern rules.
  function automatic logic [31:0] pat(int m, int n, int p);
    longint full, v, r;
    full = (64'd1 << n) - 1;
    v = 0;
    r = 0;
    case (m)
      0, 1: begin
        if (p <= n) v = (64'd1 << p) - 1;
        else        v = full & ~((64'd1 << (p - n)) - 1);
        if (m == 1) begin
          for (int i = 0; i < n; i++) if (v[i]) r[n-1-i] = 1'b1;
          v = r;
        end
      end
      2: v = 64'd1 << p;
      default: v = (p < n) ? (64'd1 << p) : (64'd1 << (2 * (n - 1) - p));
    endcase
    return v[31:0];
  endfunction

  function automatic int period(int m, int n);
    return (m < 2) ? 2 * n : (m == 2) ? n : 2 * (n - 1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N  = (g == 0) ? 8 : 4;
    localparam int TD = (g == 0) ? 4 : 2;
    logic [N-1:0] led;
    logic         tick, done;

    led_pattern_gen #(.N_LED(N), .TICK_DIV(TD)) dut (
      .clk50M(clk), .reset(rst_n), .mode(mode), .run(run),
      .led(led), .tick(tick), .cycle_done(done)
    );

    ent_t        q[$];
    ent_t        e;
    int          mc = 0, nc = 0, act = 0, div = 0, pos = 0;
    int          pin1 = 0, pin2 = 0;
    logic [31:0] last = '0;

    // Reference model: position within the current pattern plus a step timer.
    always @(posedge clk) begin
      mc++;
      if (!rst_n) begin
        act = 0; div = 0; pos = 0; pin1 = 0; pin2 = 0;
      end else begin
        if (pin2 != act) begin
          act = pin2; div = 0; pos = 0;
          q.push_back('{mc, pat(act, N, 0), 1'b0, 1'b0});
        end else if (run) begin
          if (div == TD - 1) begin
            div = 0;
            pos = (pos + 1) % period(act, N);
            q.push_back('{mc, pat(act, N, pos), 1'b1, pos == 0});
          end else div++;
        end
        pin2 = pin1;
        pin1 = int'(mode);
      end
    end

    always @(negedge clk) begin
      nc++;
      if (!rst_n) begin
        q.delete();
        last = '0;
        checks++;
        if (led != '0 || tick || done) begin
          failures++;
          $display("FAIL cfg%0d reset_state cyc=%0d led=%h tick=%b done=%b required led=0 tick=0 done=0",
                   g, nc, led, tick, done);
        end
      end else begin
        while (q.size() > 0 && q[0].cyc < nc) begin
          e = q.pop_front();
          checks++;
          failures++;
          $display("FAIL cfg%0d missed_event cyc=%0d required led=%h tick=%b", g, e.cyc, e.led, e.tk);
        end
        checks++;
        if (q.size() > 0 && q[0].cyc == nc) begin
          e = q.pop_front();
          if (led != e.led[N-1:0] || tick != e.tk || done != e.dn) begin
            failures++;
            $display("FAIL cfg%0d step cyc=%0d got led=%h tick=%b done=%b required led=%h tick=%b done=%b",
                     g, nc, led, tick, done, e.led[N-1:0], e.tk, e.dn);
          end
          last = e.led;
        end else if (led != last[N-1:0] || tick || done) begin
          failures++;
          $display("FAIL cfg%0d hold cyc=%0d got led=%h tick=%b done=%b required led=%h tick=0 done=0",
                   g, nc, led, tick, done, last[N-1:0]);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; run = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(80);
    mode = 2'd1; step(90);
    mode = 2'd2; step(60);
    mode = 2'd3; step(80);
    // Reach a mid-fill value in mode 0, then jump to the chaser
    mode = 2'd0; step(20);
    mode = 2'd2; step(30);
    run = 1'b0; step(10);
    run = 1'b1; step(30);
    // Reset asserted mid-count
    mode = 2'd0; step(6);
    rst_n = 1'b0; step(3);
    rst_n = 1'b1; step(40);
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if (i == 700) rst_n = 1'b0;
      if (i == 702) rst_n = 1'b1;
      step(1);
    end
    run = 1'b1;
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
